stream_demux_8bus_1_4: RTL and testbench



---
 rtl/demux_pkg.sv | 20 ++
 rtl/demux_slot.sv | 46 ++++
 rtl/stream_demux_8bus_1_4.sv | 73 +++++++
 tb/tb_stream_demux_8bus_1_4.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants for the 1:4 stream demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int SEL_W         = 2;
  localparam int N_CH          = 4;
  localparam int CH_A          = 0;
  localparam int CH_B          = 1;
  localparam int CH_C          = 2;
  localparam int CH_D          = 3;
  localparam int DEFAULT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module      : demux_slot
// Description : One-entry valid/ready register slice for a single channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_free
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // i_load is only raised by the parent while o_free is high, so a load
  // always wins over a drain and a same-cycle refill leaves no bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_free  = !r_valid || i_ready;

endmodule

`default_nettype wire

// File: rtl/stream_demux_8bus_1_4.sv
// ============================================================================
// Module      : stream_demux_8bus_1_4
// Description : Registered 1:4 bus demultiplexer with per-channel flow control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_8bus_1_4
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data_a,
  output logic [WIDTH-1:0] o_data_b,
  output logic [WIDTH-1:0] o_data_c,
  output logic [WIDTH-1:0] o_data_d,
  output logic [N_CH-1:0]  o_valid,
  input  logic [N_CH-1:0]  i_ready,
  output logic [CNT_W-1:0] o_xfer_cnt
);

  logic [N_CH-1:0]  w_free;
  logic [N_CH-1:0]  w_load;
  logic [WIDTH-1:0] w_slot_data [N_CH];
  logic             w_accept;
  logic [CNT_W-1:0] r_xfer_cnt;

  // Combinational through i_ready; integrators needing a registered ready
  // put a skid buffer in front.
  assign o_ready  = w_free[i_sel];
  assign w_accept = i_valid && o_ready;

  for (genvar n = 0; n < N_CH; n++) begin : g_slot
    assign w_load[n] = w_accept && (i_sel == SEL_W'(n));

    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load[n]),
      .i_data  (i_data),
      .o_data  (w_slot_data[n]),
      .o_valid (o_valid[n]),
      .i_ready (i_ready[n]),
      .o_free  (w_free[n])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_accept) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  assign o_xfer_cnt = r_xfer_cnt;
  assign o_data_a   = w_slot_data[CH_A];
  assign o_data_b   = w_slot_data[CH_B];
  assign o_data_c   = w_slot_data[CH_C];
  assign o_data_d   = w_slot_data[CH_D];

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_8bus_1_4.sv
// ============================================================================
// Module      : tb_stream_demux_8bus_1_4
// Description : Scoreboard-based bench for the 1:4 stream demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_demux_8bus_1_4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = '0;
  logic [1:0]  sel = '0;
  logic        valid = 1'b0;
  logic        o_ready;
  logic [7:0]  o_data_a, o_data_b, o_data_c, o_data_d;
  logic [3:0]  o_valid;
  logic [3:0]  ready = '0;
  logic [15:0] o_xfer_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt = '0;
  logic [7:0]  sb_q [4][$];
  logic        prev_stall = 1'b0;
  logic [1:0]  prev_sel = '0;
  logic [7:0]  prev_data = '0;

  stream_demux_8bus_1_4 #(.WIDTH(8), .CNT_W(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (data),
    .i_sel      (sel),
    .i_valid    (valid),
    .o_ready    (o_ready),
    .o_data_a   (o_data_a),
    .o_data_b   (o_data_b),
    .o_data_c   (o_data_c),
    .o_data_d   (o_data_d),
    .o_valid    (o_valid),
    .i_ready    (ready),
    .o_xfer_cnt (o_xfer_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] chan_data(int n);
    case (n)
      0:       return o_data_a;
      1:       return o_data_b;
      2:       return o_data_c;
      default: return o_data_d;
    endcase
  endfunction

  // Scoreboard: sampled mid-cycle, so every handshake seen here happens on
  // the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) sb_q[n].delete();
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (o_valid[n] && ready[n]) begin
          checks++;
          if (sb_q[n].size() == 0) begin
            failures++;
            $display("FAIL sb_underflow ch%0d got=%h expected=<no beat queued>", n, chan_data(n));
          end else begin
            logic [7:0] exp_d;
            exp_d = sb_q[n].pop_front();
            if (chan_data(n) !== exp_d) begin
              failures++;
              $display("FAIL sb_data ch%0d got=%h expected=%h", n, chan_data(n), exp_d);
            end
          end
        end
      end
      if (prev_stall && valid) begin
        checks++;
        if (sel !== prev_sel || data !== prev_data) begin
          failures++;
          $display("FAIL producer_stable got=%0d/%h expected=%0d/%h", sel, data, prev_sel, prev_data);
        end
      end
      if (valid && o_ready) begin
        sb_q[sel].push_back(data);
        exp_cnt = exp_cnt + 16'd1;
      end
      prev_stall = valid && !o_ready;
      prev_sel   = sel;
      prev_data  = data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (o_valid !== 4'b0000 || o_xfer_cnt !== 16'd0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl got=%b/%h/%b expected=0000/0000/1", o_valid, o_xfer_cnt, o_ready);
    end
    checks++;
    if ({o_data_a, o_data_b, o_data_c, o_data_d} !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got=%h expected=00000000", {o_data_a, o_data_b, o_data_c, o_data_d});
    end
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_route();
    ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      valid = 1'b1; sel = 2'(i); data = 8'(i + 1);
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
        failures++;
        $display("FAIL route_ready ch%0d got=%b expected=1", i, o_ready);
      end
      cyc();
      valid = 1'b0;
      #1;
      checks++;
      if (o_valid !== 4'(1 << i) || chan_data(i) !== 8'(i + 1)) begin
        failures++;
        $display("FAIL route_out ch%0d got=%b/%h expected=%b/%h", i, o_valid, chan_data(i), 4'(1 << i), 8'(i + 1));
      end
    end
    cyc();
    checks++;
    if (o_xfer_cnt !== 16'd4 || o_valid !== 4'b0000) begin
      failures++;
      $display("FAIL route_cnt got=%0d/%b expected=4/0000", o_xfer_cnt, o_valid);
    end
  endtask

  task automatic test_stall_isolation();
    ready = 4'b1110;
    cyc();
    valid = 1'b1; sel = 2'd0; data = 8'hA5;
    cyc();
    data = 8'h5A;
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_data_a !== 8'hA5 || o_valid[0] !== 1'b1) begin
      failures++;
      $display("FAIL stall_block got=%b/%h/%b expected=0/a5/1", o_ready, o_data_a, o_valid[0]);
    end
    cyc();
    checks++;
    if (o_ready !== 1'b0 || o_data_a !== 8'hA5) begin
      failures++;
      $display("FAIL stall_hold got=%b/%h expected=0/a5", o_ready, o_data_a);
    end
    valid = 1'b0;
    cyc();
    valid = 1'b1; sel = 2'd1; data = 8'h3C;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_other_ready got=%b expected=1", o_ready);
    end
    cyc();
    valid = 1'b0;
    #1;
    checks++;
    if (o_data_b !== 8'h3C || o_valid !== 4'b0011 || o_data_a !== 8'hA5) begin
      failures++;
      $display("FAIL stall_other_out got=%h/%b/%h expected=3c/0011/a5", o_data_b, o_valid, o_data_a);
    end
    ready = 4'b1111;
    cyc();
    valid = 1'b1; sel = 2'd0; data = 8'h5A;
    cyc();
    valid = 1'b0;
    #1;
    checks++;
    if (o_data_a !== 8'h5A || o_valid !== 4'b0001) begin
      failures++;
      $display("FAIL stall_release got=%h/%b expected=5a/0001", o_data_a, o_valid);
    end
  endtask

  task automatic test_same_slot_refill();
    ready = 4'b1111;
    cyc();
    valid = 1'b1; sel = 2'd2; data = 8'h11;
    cyc();
    data = 8'h22;
    #1;
    checks++;
    if (o_valid[2] !== 1'b1 || o_data_c !== 8'h11 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL refill_pre got=%b/%h/%b expected=1/11/1", o_valid[2], o_data_c, o_ready);
    end
    cyc();
    valid = 1'b0;
    #1;
    checks++;
    if (o_valid[2] !== 1'b1 || o_data_c !== 8'h22) begin
      failures++;
      $display("FAIL refill_post got=%b/%h expected=1/22", o_valid[2], o_data_c);
    end
    cyc();
    checks++;
    if (o_valid[2] !== 1'b0 || o_data_c !== 8'h22) begin
      failures++;
      $display("FAIL refill_drain got=%b/%h expected=0/22", o_valid[2], o_data_c);
    end
  endtask

  task automatic test_back_to_back();
    ready = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      cyc();
      valid = 1'b1; sel = 2'd3; data = 8'(i);
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready beat%0d got=%b expected=1", i, o_ready);
      end
      if (i > 0) begin
        checks++;
        if (o_valid[3] !== 1'b1 || o_data_d !== 8'(i - 1)) begin
          failures++;
          $display("FAIL b2b_data beat%0d got=%b/%h expected=1/%h", i, o_valid[3], o_data_d, 8'(i - 1));
        end
      end
    end
    cyc();
    valid = 1'b0;
    #1;
    checks++;
    if (o_valid[3] !== 1'b1 || o_data_d !== 8'h0F || o_xfer_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL b2b_last got=%b/%h/%0d expected=1/0f/%0d", o_valid[3], o_data_d, o_xfer_cnt, exp_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    int remaining;
    ready = 4'b1111;
    cyc();
    remaining = 65535 - int'(exp_cnt);
    valid = 1'b1; sel = 2'd3; data = 8'hE7;
    repeat (remaining) cyc();
    valid = 1'b0;
    #1;
    checks++;
    if (o_xfer_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_preload got=%h expected=ffff", o_xfer_cnt);
    end
    cyc();
    valid = 1'b1; data = 8'h7E;
    cyc();
    valid = 1'b0;
    #1;
    checks++;
    if (o_xfer_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL cnt_wrap got=%h expected=0000", o_xfer_cnt);
    end
  endtask

  task automatic test_async_reset();
    ready = 4'b1010;
    cyc();
    valid = 1'b1; sel = 2'd0; data = 8'h77;
    cyc();
    sel = 2'd2; data = 8'h99;
    cyc();
    valid = 1'b0;
    #1;
    checks++;
    if (o_valid !== 4'b0101) begin
      failures++;
      $display("FAIL areset_setup got=%b expected=0101", o_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 4'b0000 || o_xfer_cnt !== 16'd0 || o_ready !== 1'b1 ||
        {o_data_a, o_data_b, o_data_c, o_data_d} !== 32'd0) begin
      failures++;
      $display("FAIL areset_immediate got=%b/%h/%b/%h expected=0000/0000/1/00000000",
               o_valid, o_xfer_cnt, o_ready, {o_data_a, o_data_b, o_data_c, o_data_d});
    end
    valid = 1'b1; sel = 2'd1; data = 8'hFF;
    cyc();
    checks++;
    if (o_xfer_cnt !== 16'd0 || o_valid !== 4'b0000) begin
      failures++;
      $display("FAIL areset_hold got=%h/%b expected=0000/0000", o_xfer_cnt, o_valid);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    ready = 4'b1111;
    cyc();
    valid = 1'b1; sel = 2'd1; data = 8'hC3;
    cyc();
    valid = 1'b0;
    #1;
    checks++;
    if (o_data_b !== 8'hC3 || o_valid !== 4'b0010 || o_xfer_cnt !== 16'd1) begin
      failures++;
      $display("FAIL areset_resume got=%h/%b/%0d expected=c3/0010/1", o_data_b, o_valid, o_xfer_cnt);
    end
  endtask

  task automatic test_drain();
    repeat (2) cyc();
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (sb_q[n].size() != 0) begin
        failures++;
        $display("FAIL drain_empty ch%0d got=%0d expected=0", n, sb_q[n].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_stall_isolation();
    test_same_slot_refill();
    test_back_to_back();
    test_counter_wrap();
    test_async_reset();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
